// File: rtl/hc595_pkg.sv
// hc595_pkg: shared constants and FSM state type for the 74HC595 serializer.
package hc595_pkg;

    localparam int FRAME_BITS = 14;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic DS_RST   = 1'b0;
    localparam logic SHCP_RST = 1'b0;
    localparam logic STCP_RST = 1'b0;
    localparam logic OE_RST   = 1'b1;
    localparam logic DONE_RST = 1'b0;

endpackage

// File: rtl/hc595_pwm.sv
// hc595_pwm: frame counter and output-enable gating for display dimming.
// Only instantiated when HC595_PWM_EN is defined.
module hc595_pwm
    import hc595_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       load,
    input  logic       frame_done,
    input  logic [2:0] brightness,
    output logic       oe
);

    logic [2:0] frame_cnt;
    logic [2:0] frame_cnt_inc;
    logic [2:0] bright_q;

    assign frame_cnt_inc = frame_cnt + 3'd1;

    // Sample brightness at LOAD; on each frame_done advance p and decide oe for the next frame period.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt <= 3'd0;
            bright_q  <= 3'd0;
            oe        <= OE_RST;
        end else begin
            if (load) begin
                bright_q <= brightness;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt_inc;
                oe        <= (frame_cnt_inc > bright_q);
            end
        end
    end

endmodule

// File: rtl/hc595_shifter.sv
// hc595_shifter: serializes {seg, sel} into two cascaded 74HC595s, free-running
// LOAD -> SHIFT -> LATCH frames. Optional dimming is enabled with HC595_PWM_EN.
module hc595_shifter
    import hc595_pkg::*;
#(
    parameter int BIT_CYC = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [5:0] sel,
    input  logic [7:0] seg,
    input  logic [2:0] brightness,
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe,
    output logic       frame_done
);

    localparam int CW = $clog2(BIT_CYC);
    localparam logic [CW-1:0] C_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] C_HALF = CW'(BIT_CYC / 2);
    localparam logic [3:0]    K_LAST = 4'(FRAME_BITS - 1);

    state_t                  state, state_n;
    logic [3:0]              bit_idx, bit_idx_n;
    logic [CW-1:0]           sub_cnt, sub_cnt_n;
    logic [FRAME_BITS-1:0]   shadow, shadow_n;
    logic                    ds_n, shcp_n, stcp_n, done_n;

    // Next-state logic, then pin values derived from the upcoming state so the pins can be registered.
    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        sub_cnt_n = sub_cnt;
        shadow_n  = shadow;
        ds_n      = DS_RST;
        shcp_n    = SHCP_RST;
        stcp_n    = STCP_RST;
        done_n    = DONE_RST;

        case (state)
            LOAD: begin
                shadow_n  = {seg, sel};
                bit_idx_n = 4'd0;
                sub_cnt_n = '0;
                state_n   = SHIFT;
            end
            SHIFT: begin
                if (sub_cnt == C_LAST) begin
                    sub_cnt_n = '0;
                    if (bit_idx == K_LAST) begin
                        bit_idx_n = 4'd0;
                        state_n   = LATCH;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end else begin
                    sub_cnt_n = sub_cnt + CW'(1);
                end
            end
            LATCH: begin
                if (sub_cnt == C_LAST) begin
                    sub_cnt_n = '0;
                    state_n   = LOAD;
                end else begin
                    sub_cnt_n = sub_cnt + CW'(1);
                end
            end
            default: begin
                state_n = LOAD;
            end
        endcase

        case (state_n)
            SHIFT: begin
                ds_n   = shadow_n[K_LAST - bit_idx_n];
                shcp_n = (sub_cnt_n >= C_HALF);
            end
            LATCH: begin
                stcp_n = (sub_cnt_n >= C_HALF);
                done_n = (sub_cnt_n == C_LAST);
            end
            default: begin
                ds_n = DS_RST;
            end
        endcase
    end

    // State, counters, shadow word and registered pin outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= LOAD;
            bit_idx    <= 4'd0;
            sub_cnt    <= '0;
            shadow     <= '0;
            ds         <= DS_RST;
            shcp       <= SHCP_RST;
            stcp       <= STCP_RST;
            frame_done <= DONE_RST;
        end else begin
            state      <= state_n;
            bit_idx    <= bit_idx_n;
            sub_cnt    <= sub_cnt_n;
            shadow     <= shadow_n;
            ds         <= ds_n;
            shcp       <= shcp_n;
            stcp       <= stcp_n;
            frame_done <= done_n;
        end
    end

`ifdef HC595_PWM_EN
    hc595_pwm u_pwm (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .load       (state == LOAD),
        .frame_done (frame_done),
        .brightness (brightness),
        .oe         (oe)
    );
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;

    // Keep the display blanked until the first complete frame has been latched.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            oe <= OE_RST;
        end else if (frame_done) begin
            oe <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_hc595_shifter.sv
// tb_hc595_shifter: randomized self-checking bench for hc595_shifter.
// Expected pin values come from frame timing arithmetic and the word/brightness
// captured at each frame's LOAD cycle.
module tb_hc595_shifter;

    localparam int BIT_CYC   = 4;
    localparam int PERIOD    = 1 + 15 * BIT_CYC;
    localparam int SHIFT_END = 14 * BIT_CYC;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [5:0] sel;
    logic [7:0] seg;
    logic [2:0] brightness;
    logic       ds, shcp, stcp, oe, frame_done;

    int          passCount  = 0;
    int          checkCount = 0;
    int          t          = 0;
    int          mode       = 0;
    logic [13:0] frameWord   [0:255];
    logic [2:0]  frameBright [0:255];
    logic [13:0] shiftAcc;
    int          riseCount;
    logic        prevShcp;
    bit          countOn    = 1'b0;
    int          onFrames   = 0;

    hc595_shifter #(.BIT_CYC(BIT_CYC)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sel        (sel),
        .seg        (seg),
        .brightness (brightness),
        .ds         (ds),
        .shcp       (shcp),
        .stcp       (stcp),
        .oe         (oe),
        .frame_done (frame_done)
    );

    // 50 MHz system clock
    initial forever #10 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, got, exp, t);
    endtask

    task automatic applyStimulus(input int ph, input int f);
        if (mode == 0) begin
            if (f == 0 && ph == 20) seg = 8'hF9;
        end else begin
            if ($urandom_range(0, 39) == 0) begin
                seg = 8'($urandom);
                sel = 6'($urandom);
            end
            if (mode == 1 && $urandom_range(0, 149) == 0) brightness = 3'($urandom);
        end
    endtask

    task automatic clearTracking();
        t         = 0;
        shiftAcc  = '0;
        riseCount = 0;
        prevShcp  = 1'b0;
    endtask

    // Check one cycle at the current negedge, drive inputs, then advance to the next negedge.
    task automatic stepCycle();
        int   ph, f, fi, k, c;
        logic eDs, eShcp, eStcp, eDone, eOe;
        ph = t % PERIOD;
        f  = t / PERIOD;
        fi = f % 256;
        eDs = 1'b0; eShcp = 1'b0; eStcp = 1'b0; eDone = 1'b0;
        if (ph >= 1 && ph <= SHIFT_END) begin
            k     = (ph - 1) / BIT_CYC;
            c     = (ph - 1) % BIT_CYC;
            eDs   = frameWord[fi][13-k];
            eShcp = (c >= BIT_CYC / 2);
        end else if (ph > SHIFT_END) begin
            c     = ph - 1 - SHIFT_END;
            eStcp = (c >= BIT_CYC / 2);
            eDone = (c == BIT_CYC - 1);
        end
        if (f == 0) eOe = 1'b1;
`ifdef HC595_PWM_EN
        else eOe = !((f % 8) <= int'(frameBright[(f - 1) % 256]));
`else
        else eOe = 1'b0;
`endif
        checkOutput("ds", 32'(ds), 32'(eDs));
        checkOutput("shcp", 32'(shcp), 32'(eShcp));
        checkOutput("stcp", 32'(stcp), 32'(eStcp));
        checkOutput("frame_done", 32'(frame_done), 32'(eDone));
        checkOutput("oe", 32'(oe), 32'(eOe));

        if (ph == 0) begin
            shiftAcc  = '0;
            riseCount = 0;
        end
        if (shcp === 1'b1 && prevShcp === 1'b0) begin
            shiftAcc = {shiftAcc[12:0], ds};
            riseCount++;
        end
        prevShcp = shcp;
        if (countOn && ph == 1 && oe === 1'b0) onFrames++;

        if (ph == PERIOD - 1) begin
            checkOutput("frame_word", 32'(shiftAcc), 32'(frameWord[fi]));
            checkOutput("shcp_rises", 32'(riseCount), 32'd14);
            if (mode == 0 && f == 0) checkOutput("basic_word", 32'(shiftAcc), 32'h3001);
            if (mode == 0 && f == 1) checkOutput("changed_word", 32'(shiftAcc), 32'h3E41);
        end

        applyStimulus(ph, f);
        if (ph == 0) begin
            frameWord[fi]   = {seg, sel};
            frameBright[fi] = brightness;
        end
        @(negedge sys_clk);
        t++;
    endtask

    task automatic runCycles(input int n, input int m);
        mode = m;
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic checkResetPins(input string tag);
        checkOutput({tag, "_ds"}, 32'(ds), 32'd0);
        checkOutput({tag, "_shcp"}, 32'(shcp), 32'd0);
        checkOutput({tag, "_stcp"}, 32'(stcp), 32'd0);
        checkOutput({tag, "_oe"}, 32'(oe), 32'd1);
        checkOutput({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic midFrameReset();
        sys_rst_n = 1'b0;
        #1;
        checkResetPins("midrst");
        repeat (2) @(negedge sys_clk);
        checkResetPins("midrst_hold");
        sys_rst_n = 1'b1;
        clearTracking();
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        seg        = 8'hC0;
        sel        = 6'b000001;
        brightness = 3'd7;
        clearTracking();
        repeat (3) @(negedge sys_clk);
        checkResetPins("reset");
        sys_rst_n = 1'b1;
        clearTracking();

        runCycles(3 * PERIOD, 0);
        runCycles(2 * PERIOD + 30, 1);
        midFrameReset();
        runCycles(5 * PERIOD, 1);

        brightness = 3'd3;
        runCycles(PERIOD, 2);
        onFrames = 0;
        countOn  = 1'b1;
        runCycles(8 * PERIOD, 2);
        countOn  = 1'b0;
`ifdef HC595_PWM_EN
        checkOutput("pwm_b3_on_frames", 32'(onFrames), 32'd4);
`else
        checkOutput("pwm_b3_on_frames", 32'(onFrames), 32'd8);
`endif

        brightness = 3'd7;
        runCycles(PERIOD, 2);
        onFrames = 0;
        countOn  = 1'b1;
        runCycles(8 * PERIOD, 2);
        countOn  = 1'b0;
        checkOutput("pwm_b7_on_frames", 32'(onFrames), 32'd8);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
